uart_frame_check: RTL and testbench

- Receive-side counterpart of the periodic banner transmitter.
- Consumes bytes from the UART receiver and frames them into CR/LF-terminated lines.
- Checks each line against the expected banner "====HELLO WORLD===" (18 chars, then 0x0D 0x0A), counts good and bad frames, and buffers every received byte in a FIFO so the transmit side can echo it.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 81 ++++++++
 rtl/uart_frame_check.sv | 174 +++++++++++++++++
 tb/tb_uart_frame_check.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, expected-banner ROM and FSM state encoding for the UART frame checker.
package uart_pkg;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] EQ = 8'h3D;

    localparam int BANNER_LEN = 18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WAIT_LF,
        S_DISCARD
    } frame_state_e;

    // "====HELLO WORLD===": positions outside the text part read as '='.
    function automatic logic [7:0] exp_char(input int index);
        case (index)
            4:       exp_char = 8'h48;
            5:       exp_char = 8'h45;
            6:       exp_char = 8'h4C;
            7:       exp_char = 8'h4C;
            8:       exp_char = 8'h4F;
            9:       exp_char = 8'h20;
            10:      exp_char = 8'h57;
            11:      exp_char = 8'h4F;
            12:      exp_char = 8'h52;
            13:      exp_char = 8'h4C;
            14:      exp_char = 8'h44;
            default: exp_char = EQ;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with registered read data and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop    = pop && (cnt_q != '0);
        do_push   = push && ((cnt_q != FULL_CNT) || do_pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rd_data_d = mem[rd_ptr_q];
        end
        if (push && !do_push) begin
            ovf_d = 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rd_data = rd_data_q;
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/uart_frame_check.sv
// Frames received bytes into CR/LF lines, checks each against the banner and echoes all bytes via a FIFO.
// Define UART_FRAME_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
module uart_frame_check
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 32,
    parameter int          MAX_LEN     = 32,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          fifo_ovf,
    output logic                          frame_ok,
    output logic                          frame_err,
    output logic [15:0]                   ok_cnt,
    output logic [15:0]                   err_cnt
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam logic [IDX_W-1:0] BANNER_IDX = IDX_W'(BANNER_LEN);
    localparam logic [IDX_W-1:0] MAX_IDX    = IDX_W'(MAX_LEN);

    frame_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mis_q, mis_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      ok_cnt_q, ok_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [23:0]      idle_q, idle_d;
`else
    logic             timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYC;
`endif

    uart_rx_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (fifo_empty),
        .cnt       (fifo_cnt),
        .ovf       (fifo_ovf)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mis_d       = mis_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CR) begin
                        state_d = S_WAIT_LF;
                        idx_d   = '0;
                    end else begin
                        mis_d   = (rx_data != exp_char(0));
                        idx_d   = IDX_W'(1);
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    if (rx_data == CR) begin
                        state_d = S_WAIT_LF;
                    end else begin
                        if ((rx_data != exp_char(int'(idx_q))) || (idx_q >= BANNER_IDX)) begin
                            mis_d = 1'b1;
                        end
                        idx_d = idx_q + IDX_W'(1);
                        // Overlong lines are swallowed up to the next LF.
                        if (idx_d == MAX_IDX) begin
                            state_d = S_DISCARD;
                        end
                    end
                end
            end
            S_WAIT_LF: begin
                if (rx_valid) begin
                    if ((rx_data == LF) && !mis_q && (idx_q == BANNER_IDX)) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end
            end
            S_DISCARD: begin
                if (rx_valid && (rx_data == LF)) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                    idx_d       = '0;
                    mis_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        // A byte arriving in the expiry cycle takes priority over the timeout.
        idle_d = '0;
        if ((state_q != S_IDLE) && !rx_valid) begin
            if (idle_q == (TIMEOUT_CYC - 24'd1)) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                idx_d       = '0;
                mis_d       = 1'b0;
            end else begin
                idle_d = idle_q + 24'd1;
            end
        end
`endif

        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (frame_ok_d && (ok_cnt_q != 16'hFFFF)) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end
        if (frame_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            mis_q       <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mis_q       <= mis_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
`ifdef UART_FRAME_TIMEOUT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign ok_cnt    = ok_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_check.sv
// Scoreboard bench for uart_frame_check: frame pulses and FIFO read data are predicted at drive time.
module tb_uart_frame_check;

    localparam int  FIFO_DEPTH = 32;
    localparam int  MAX_LEN    = 32;
    localparam int  CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int  TIMEOUT    = 100;
    localparam time PERIOD     = 10;

    logic             clk;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_ovf;
    logic             frame_ok;
    logic             frame_err;
    logic [15:0]      ok_cnt;
    logic [15:0]      err_cnt;

    typedef struct { bit ok; time due; } frame_exp_t;
    typedef struct { logic [7:0] data; time due; } rd_exp_t;

    frame_exp_t  exp_fr[$];
    rd_exp_t     exp_rd[$];
    logic [7:0]  fifo_m[$];
    bit          ovf_m;
    logic [15:0] exp_ok;
    logic [15:0] exp_err;
    int          m_len;
    bit          m_good;
    bit          m_cr;
    bit          m_disc;
    int          checks = 0;
    int          errors = 0;
    string       banner = "====HELLO WORLD===";

    uart_frame_check #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (24'(TIMEOUT))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_cnt   (fifo_cnt),
        .fifo_ovf   (fifo_ovf),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .ok_cnt     (ok_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame pulses must appear exactly at their predicted sample time and nowhere else.
    always @(negedge clk) begin
        frame_exp_t fe;
        if (!rst) begin
            if (exp_fr.size() > 0 && exp_fr[0].due <= $time) begin
                fe = exp_fr.pop_front();
                checks++;
                if (frame_ok !== fe.ok || frame_err !== (fe.ok ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL frame_pulse t=%0t: got ok=%b err=%b, expected ok=%b err=%b",
                             $time, frame_ok, frame_err, fe.ok, !fe.ok);
                end
            end else if (frame_ok || frame_err) begin
                checks++;
                errors++;
                $display("[TB] FAIL frame_unexpected t=%0t: got ok=%b err=%b, expected no pulse",
                         $time, frame_ok, frame_err);
            end
        end
    end

    always @(negedge clk) begin
        rd_exp_t re;
        if (!rst && exp_rd.size() > 0 && exp_rd[0].due <= $time) begin
            re = exp_rd.pop_front();
            checks++;
            if (rd_data !== re.data) begin
                errors++;
                $display("[TB] FAIL fifo_rd_data t=%0t: got 0x%02h, expected 0x%02h", $time, rd_data, re.data);
            end
        end
    end

    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_clear();
        m_len  = 0;
        m_good = 1'b1;
        m_cr   = 1'b0;
        m_disc = 1'b0;
    endtask

    task automatic model_result(input bit ok, input time due);
        frame_exp_t fe;
        fe.ok  = ok;
        fe.due = due;
        exp_fr.push_back(fe);
        if (ok && exp_ok != 16'hFFFF) exp_ok = exp_ok + 16'd1;
        if (!ok && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        model_clear();
    endtask

    task automatic model_frame(input logic [7:0] b, input time due);
        if (m_cr) begin
            model_result((b == 8'h0A) && m_good && (m_len == banner.len()), due);
        end else if (m_disc) begin
            if (b == 8'h0A) model_result(1'b0, due);
        end else if (b == 8'h0D) begin
            m_cr = 1'b1;
        end else begin
            if (m_len >= banner.len() || b != banner[m_len]) m_good = 1'b0;
            m_len++;
            if (m_len == MAX_LEN) m_disc = 1'b1;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic model_pop();
        rd_exp_t re;
        if (fifo_m.size() > 0) begin
            re.data = fifo_m.pop_front();
            re.due  = $time + PERIOD;
            exp_rd.push_back(re);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        exp_fr.delete();
        exp_rd.delete();
        fifo_m.delete();
        ovf_m   = 1'b0;
        exp_ok  = '0;
        exp_err = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        rd_en    = 1'b0;
        model_push(b);
        model_frame(b, $time + PERIOD);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic pop_byte();
        @(negedge clk);
        rx_valid = 1'b0;
        rd_en    = 1'b1;
        model_pop();
    endtask

    task automatic push_pop(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        rd_en    = 1'b1;
        model_pop();
        model_push(b);
        model_frame(b, $time + PERIOD);
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b, expected 1", fifo_empty); end
        checks++; if (fifo_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d, expected 0", fifo_cnt); end
        checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b, expected 0", fifo_ovf); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got 0x%02h, expected 0x00", rd_data); end
        checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got ok=%b err=%b, expected 0 0", frame_ok, frame_err); end
        checks++; if (ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d, expected 0/0", ok_cnt, err_cnt); end
    endtask

    task automatic test_banner_ok();
        do_reset();
        send_line(banner);
        go_idle();
        checks++; if (ok_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL banner_ok_counters: got %0d/%0d, expected 1/0", ok_cnt, err_cnt); end
        checks++; if (fifo_cnt !== CNT_W'(20)) begin errors++; $display("[TB] FAIL banner_ok_fifo_cnt: got %0d, expected 20", fifo_cnt); end
        for (int i = 0; i < 20; i++) pop_byte();
        go_idle();
        checks++; if (fifo_empty !== 1'b1 || fifo_cnt !== '0) begin errors++; $display("[TB] FAIL banner_ok_drain: got empty=%b cnt=%0d, expected 1/0", fifo_empty, fifo_cnt); end
        checks++; if (rd_data !== 8'h0A) begin errors++; $display("[TB] FAIL banner_ok_last_byte: got 0x%02h, expected 0x0A", rd_data); end
        pop_byte();
        go_idle();
        checks++; if (rd_data !== 8'h0A || fifo_cnt !== '0) begin errors++; $display("[TB] FAIL pop_empty_hold: got 0x%02h cnt=%0d, expected 0x0A cnt=0", rd_data, fifo_cnt); end
    endtask

    task automatic test_banner_err();
        do_reset();
        send_line("====HELLO WORLX===");
        go_idle();
        checks++; if (ok_cnt !== 16'd0 || err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL banner_err_counters: got %0d/%0d, expected 0/1", ok_cnt, err_cnt); end
    endtask

    task automatic test_cr_then_garbage();
        do_reset();
        send_str(banner);
        send_byte(8'h0D);
        send_byte(8'h41);
        go_idle();
        send_line(banner);
        go_idle();
        checks++; if (ok_cnt !== 16'd1 || err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL cr_garbage_counters: got %0d/%0d, expected 1/1", ok_cnt, err_cnt); end
    endtask

    task automatic test_discard();
        do_reset();
        for (int i = 0; i < 40; i++) send_byte(8'h41);
        send_byte(8'h0D);
        send_byte(8'h0A);
        go_idle();
        checks++; if (ok_cnt !== 16'd0 || err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL discard_counters: got %0d/%0d, expected 0/1", ok_cnt, err_cnt); end
        checks++; if (fifo_cnt !== CNT_W'(FIFO_DEPTH) || fifo_ovf !== 1'b1) begin errors++; $display("[TB] FAIL discard_fifo: got cnt=%0d ovf=%b, expected 32/1", fifo_cnt, fifo_ovf); end
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int i = 0; i < 31; i++) send_byte(8'(8'h30 + i));
        go_idle();
        checks++; if (fifo_cnt !== CNT_W'(31) || fifo_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pre: got cnt=%0d ovf=%b, expected 31/0", fifo_cnt, fifo_ovf); end
        send_byte(8'h4F);
        send_byte(8'h50);
        go_idle();
        checks++; if (fifo_cnt !== CNT_W'(32) || fifo_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_post: got cnt=%0d ovf=%b, expected 32/1", fifo_cnt, fifo_ovf); end
        for (int i = 0; i < FIFO_DEPTH; i++) pop_byte();
        go_idle();
        checks++; if (fifo_empty !== 1'b1 || fifo_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got empty=%b ovf=%b, expected 1/1", fifo_empty, fifo_ovf); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) send_byte(8'(8'h60 + i));
        go_idle();
        checks++; if (fifo_cnt !== CNT_W'(32) || fifo_ovf !== 1'b0) begin errors++; $display("[TB] FAIL full_pre: got cnt=%0d ovf=%b, expected 32/0", fifo_cnt, fifo_ovf); end
        push_pop(8'h21);
        go_idle();
        checks++; if (fifo_cnt !== CNT_W'(32) || fifo_ovf !== 1'b0) begin errors++; $display("[TB] FAIL full_push_pop: got cnt=%0d ovf=%b, expected 32/0", fifo_cnt, fifo_ovf); end
        for (int i = 0; i < FIFO_DEPTH; i++) pop_byte();
        go_idle();
        push_pop(8'h22);
        go_idle();
        checks++; if (fifo_cnt !== CNT_W'(1) || rd_data !== 8'h21) begin errors++; $display("[TB] FAIL empty_push_pop: got cnt=%0d rd=0x%02h, expected 1/0x21", fifo_cnt, rd_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_line(banner);
        send_line(banner);
        send_line("====HELLO WORLD==");
        go_idle();
        checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin errors++; $display("[TB] FAIL b2b_counters: got %0d/%0d, expected %0d/%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
        checks++; if (fifo_ovf !== ovf_m || fifo_cnt !== CNT_W'(fifo_m.size())) begin errors++; $display("[TB] FAIL b2b_fifo: got cnt=%0d ovf=%b, expected %0d/%b", fifo_cnt, fifo_ovf, fifo_m.size(), ovf_m); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_str("====HEL");
        go_idle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse: got ok=%b err=%b, expected 0 0", frame_ok, frame_err); end
        end
        checks++; if (fifo_empty !== 1'b1 || err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midreset_state: got empty=%b err_cnt=%0d, expected 1/0", fifo_empty, err_cnt); end
        send_line(banner);
        go_idle();
        checks++; if (ok_cnt !== 16'd1) begin errors++; $display("[TB] FAIL midreset_recover: got ok_cnt=%0d, expected 1", ok_cnt); end
    endtask

`ifdef UART_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        time t_last;
        int  cycles;
        do_reset();
        send_byte(8'h3D);
        send_byte(8'h3D);
        t_last = $time;
        model_result(1'b0, t_last + PERIOD * (TIMEOUT + 1));
        @(negedge clk);
        rx_valid = 1'b0;
        cycles = 0;
        while (cycles < 3 * TIMEOUT) begin
            @(posedge clk);
            cycles++;
            #1;
            if (frame_err) break;
        end
        checks++; if (cycles !== TIMEOUT) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d, expected %0d", cycles, TIMEOUT); end
        go_idle();
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL timeout_err_cnt: got %0d, expected 1", err_cnt); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        model_clear();
        $display("[TB] starting uart_frame_check bench");
        test_reset();
        test_banner_ok();
        test_banner_err();
        test_cr_then_garbage();
        test_discard();
        test_fifo_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_FRAME_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_fr.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d frame/%0d read entries pending, expected 0/0", exp_fr.size(), exp_rd.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
